// File: rtl/fake_mario_sw_poller.sv
// Avalon-MM read master that polls the switch PIO, debounces the sample and
// publishes a stable switch vector with rise/fall masks and a change pulse.
//
// state     | meaning
// ----------+-------------------------------------------------
// IDLE      | waiting for a poll tick
// REQ       | avm_read asserted, waiting for the fabric to accept
// WAIT_DATA | read accepted, waiting for readdatavalid or timeout
module fake_mario_sw_poller #(
    parameter int POLL_DIV     = 50000,
    parameter int STABLE_COUNT = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        err_clear,
    output logic [1:0]  avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    input  logic        avm_readdatavalid,
    output logic [15:0] sw_state,
    output logic [15:0] sw_rise,
    output logic [15:0] sw_fall,
    output logic        sw_changed,
    output logic        err_timeout,
    output logic [7:0]  overrun_cnt
);
    localparam int TW = $clog2(POLL_DIV);
    localparam int OW = $clog2(TIMEOUT);
    localparam int CW = $clog2(STABLE_COUNT + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(POLL_DIV - 1);
    localparam logic [OW-1:0] TO_LAST   = OW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(STABLE_COUNT);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA} state_t;

    state_t        state;
    logic [TW-1:0] tick_cnt;
    logic [OW-1:0] to_cnt;
    logic [15:0]   last_sample;
    logic [CW-1:0] stable_cnt;
    logic [CW-1:0] cnt_next;
    logic [15:0]   sample;
    logic          tick;
    logic          capture;
    logic          timed_out;
    logic          overrun;
    logic          do_update;
    logic          unused_hi;

    assign avm_address = 2'b00;
    assign sample      = avm_readdata[15:0];
    assign unused_hi   = ^avm_readdata[31:16];
    assign tick        = enable && (tick_cnt == TICK_LAST);
    assign capture     = (state == WAIT_DATA) && avm_readdatavalid;
    assign timed_out   = (state == WAIT_DATA) && !avm_readdatavalid && (to_cnt == TO_LAST);
    assign overrun     = tick && (state != IDLE);

    always_comb begin
        cnt_next = CW'(1);
        if (sample == last_sample)
            cnt_next = (stable_cnt == CNT_MAX) ? CNT_MAX : stable_cnt + 1'b1;
        do_update = capture && (cnt_next == CNT_MAX) && (sample != sw_state);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tick_cnt <= '0;
        else if (!enable || tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            avm_read <= 1'b0;
            to_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (tick) begin
                        state    <= REQ;
                        avm_read <= 1'b1;
                    end
                end
                REQ: begin
                    if (!avm_waitrequest) begin
                        state    <= WAIT_DATA;
                        avm_read <= 1'b0;
                        to_cnt   <= '0;
                    end
                end
                WAIT_DATA: begin
                    if (avm_readdatavalid || timed_out)
                        state <= IDLE;
                    else
                        to_cnt <= to_cnt + 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    avm_read <= 1'b0;
                end
            endcase
        end
    end

    // A new event in the same cycle as err_clear takes precedence.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_timeout <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            if (timed_out)
                err_timeout <= 1'b1;
            else if (err_clear)
                err_timeout <= 1'b0;

            if (overrun)
                overrun_cnt <= err_clear ? 8'd1 :
                               (overrun_cnt == 8'hFF) ? 8'hFF : overrun_cnt + 8'd1;
            else if (err_clear)
                overrun_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_sample <= '0;
            stable_cnt  <= '0;
            sw_state    <= '0;
            sw_rise     <= '0;
            sw_fall     <= '0;
            sw_changed  <= 1'b0;
        end else begin
            sw_changed <= do_update;
            if (capture) begin
                last_sample <= sample;
                stable_cnt  <= cnt_next;
            end
            if (do_update) begin
                sw_state <= sample;
                sw_rise  <= sample & ~sw_state;
                sw_fall  <= ~sample & sw_state;
            end
        end
    end
endmodule

// File: tb/tb_fake_mario_sw_poller.sv
// Directed bench for fake_mario_sw_poller: POLL_DIV=4, STABLE_COUNT=3, TIMEOUT=8,
// with a simple slave that answers one cycle after each accepted read.
module tb_fake_mario_sw_poller;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        err_clear = 1'b0;
    logic [1:0]  avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata = '0;
    logic        avm_waitrequest = 1'b0;
    logic        avm_readdatavalid = 1'b0;
    logic [15:0] sw_state, sw_rise, sw_fall;
    logic        sw_changed, err_timeout;
    logic [7:0]  overrun_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] rsp_q[$];
    logic [31:0] slave_dflt = 32'h0000_00A5;
    logic [31:0] man_data = '0;
    bit          resp_en = 1'b1;
    bit          man_valid = 1'b0;
    bit          acc = 1'b0;

    int nvalid, nread, run, run_max;
    bit seen, found;

    fake_mario_sw_poller #(.POLL_DIV(4), .STABLE_COUNT(3), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .enable(enable), .err_clear(err_clear),
        .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid),
        .sw_state(sw_state), .sw_rise(sw_rise), .sw_fall(sw_fall), .sw_changed(sw_changed),
        .err_timeout(err_timeout), .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    // Slave: a read accepted in one cycle returns data in the following cycle.
    always @(negedge clk) acc = resp_en && avm_read && !avm_waitrequest && !reset;

    always @(posedge clk) begin
        #1;
        if (acc) begin
            avm_readdatavalid = 1'b1;
            if (rsp_q.size() > 0) avm_readdata = rsp_q.pop_front();
            else                  avm_readdata = slave_dflt;
        end else if (man_valid) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = man_data;
        end else begin
            avm_readdatavalid = 1'b0;
            avm_readdata      = '0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_read"}, {31'd0, avm_read}, 0);
        check({tag, "_state"}, {16'd0, sw_state}, 0);
        check({tag, "_rise"}, {16'd0, sw_rise}, 0);
        check({tag, "_fall"}, {16'd0, sw_fall}, 0);
        check({tag, "_changed"}, {31'd0, sw_changed}, 0);
        check({tag, "_err"}, {31'd0, err_timeout}, 0);
        check({tag, "_ovr"}, {24'd0, overrun_cnt}, 0);
    endtask

    task automatic run_until_change(input int max_cyc, output int nv, output bit sn);
        nv = 0;
        sn = 1'b0;
        for (int i = 0; i < max_cyc && !sn; i++) begin
            @(negedge clk);
            if (sw_changed) sn = 1'b1;
            else if (avm_readdatavalid) nv++;
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check_all_zero("rst0");
        check("rst0_addr", {30'd0, avm_address}, 0);
        @(posedge clk); #1 reset = 1'b0; enable = 1'b1;

        // Steady 0xA5: update after the third sample
        run_until_change(40, nvalid, seen);
        check("t1_seen", {31'd0, seen}, 1);
        check("t1_nsamples", nvalid, 3);
        check("t1_state", {16'd0, sw_state}, 32'h00A5);
        check("t1_rise", {16'd0, sw_rise}, 32'h00A5);
        check("t1_fall", {16'd0, sw_fall}, 0);
        @(negedge clk);
        check("t1_pulse_one", {31'd0, sw_changed}, 0);
        check("t1_state_hold", {16'd0, sw_state}, 32'h00A5);
        nread = 0; run = 0; run_max = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (avm_read) begin nread++; run++; if (run > run_max) run_max = run; end
            else run = 0;
        end
        check("t1_read_count", nread, 4);
        check("t1_read_width", run_max, 1);

        // Async reset clears everything, then bounce sequence
        reset = 1'b1;
        #1 check_all_zero("rst1");
        repeat (2) @(posedge clk);
        rsp_q = '{32'h00A5, 32'h00A4, 32'h00A5, 32'h00A5, 32'h00A5,
                  32'h0005, 32'h0005, 32'h0005};
        slave_dflt = 32'h0000_0005;
        @(posedge clk); #1 reset = 1'b0;
        run_until_change(60, nvalid, seen);
        check("t2_seen", {31'd0, seen}, 1);
        check("t2_nsamples", nvalid, 5);
        check("t2_state", {16'd0, sw_state}, 32'h00A5);
        run_until_change(40, nvalid, seen);
        check("t2b_seen", {31'd0, seen}, 1);
        check("t2b_nsamples", nvalid, 3);
        check("t2b_state", {16'd0, sw_state}, 32'h0005);
        check("t2b_rise", {16'd0, sw_rise}, 0);
        check("t2b_fall", {16'd0, sw_fall}, 32'h00A0);

        // Upper readdata bits ignored
        slave_dflt = 32'hFFFF_1234;
        run_until_change(40, nvalid, seen);
        check("t3_seen", {31'd0, seen}, 1);
        check("t3_state", {16'd0, sw_state}, 32'h1234);
        check("t3_rise", {16'd0, sw_rise}, 32'h1230);
        check("t3_fall", {16'd0, sw_fall}, 32'h0001);

        // Stall in REQ: read and address held, one tick dropped
        @(posedge clk); #1 avm_waitrequest = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            found = avm_read;
        end
        check("t4_read_seen", {31'd0, found}, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t4_read_hold", {31'd0, avm_read}, 1);
            check("t4_addr", {30'd0, avm_address}, 0);
        end
        @(posedge clk); #1 avm_waitrequest = 1'b0;
        repeat (4) @(negedge clk);
        check("t4_overrun", {24'd0, overrun_cnt}, 1);
        check("t4_no_timeout", {31'd0, err_timeout}, 0);
        @(posedge clk); #1 err_clear = 1'b1;
        @(posedge clk); #1 err_clear = 1'b0;
        @(negedge clk);
        check("t4_clear", {24'd0, overrun_cnt}, 0);

        // Timeout: no readdatavalid
        @(posedge clk); #1 resp_en = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            found = avm_read;
        end
        check("t5_read_seen", {31'd0, found}, 1);
        repeat (7) @(negedge clk);
        @(negedge clk);
        check("t5_err_not_yet", {31'd0, err_timeout}, 0);
        @(negedge clk);
        check("t5_err_set", {31'd0, err_timeout}, 1);
        check("t5_overrun", {24'd0, overrun_cnt}, 2);
        nread = 0;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            nread++;
            found = avm_read;
        end
        check("t5_next_read_delay", nread, 3);

        // Reset during WAIT_DATA, then late valid while idle and disabled
        @(negedge clk);
        enable = 1'b0;
        man_data = 32'h0000_FFFF;
        man_valid = 1'b1;
        reset = 1'b1;
        #1 check_all_zero("t6_rst");
        @(posedge clk); #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t6_no_change", {31'd0, sw_changed}, 0);
        end
        @(posedge clk); #1 man_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("t6_state", {16'd0, sw_state}, 0);
        check("t6_read_idle", {31'd0, avm_read}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
